ccm_lsu_adapter: RTL and testbench
==================================

# ccm_lsu_adapter

Byte-addressed load/store front end for the closely coupled memory (CCM) controller. It accepts one load/store request at a time from the core's LSU, checks alignment, and drives the CCM controller's word-wide read and write ports. Sub-word loads are sign- or zero-extended, and sub-word stores use a read-modify-write sequence because the controller has no byte enables. It sits between the LSU and `ccm_controller`, and the controller's read data returns one cycle after the read request.

## Interface

Parameters:
- `ADDR_WIDTH`, default 11: CCM word-address width. The byte address is `ADDR_WIDTH+2` bits.
- `DATA_WIDTH`, default 32: data width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  LSU request valid.
- `req_ready`  out  1  adapter can accept a request; high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_WIDTH+2  byte address.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  zero-extend sub-word loads.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response pulse. No backpressure; the LSU always accepts it.
- `rsp_rdata`  out  32  load result. Holds until the next load or error response.
- `rsp_err`  out  1  access fault; valid with `rsp_valid`.
- `cntlr_rd`  out  1  read request to the CCM controller.
- `cntlr_raddr`  out  ADDR_WIDTH  read word address.
- `cntlr_rd_data`  in  32  read data; valid when `cntlr_rd_valid` is high.
- `cntlr_rd_valid`  in  1  read data valid; arrives one cycle after `cntlr_rd`.
- `cntlr_wr`  out  1  write request.
- `cntlr_waddr`  out  ADDR_WIDTH  write word address.
- `cntlr_wr_data`  out  32  write data.

## Operation

- A request is accepted on `req_valid & req_ready`. Accepting latches `req_we`, `req_addr`, `req_size`, `req_unsigned` and `req_wdata`.
- Faults:
  - Conditions: `req_size`=11; half with `addr[0]`=1; word with `addr[1:0]`≠0.
  - Effect: no CCM access; go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- FSM transitions:
  - IDLE → RD on a legal load or a legal sub-word store.
  - IDLE → WR on a legal word store.
  - IDLE → RESP on a fault.
  - RD → RWAIT unconditionally.
  - RWAIT stays in RWAIT until `cntlr_rd_valid` is high. It then goes to RESP for a load, or to WR for a store.
  - WR → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Per-state outputs:
  - RD: `cntlr_rd`=1.
  - WR: `cntlr_wr`=1.
  - RESP: `rsp_valid`=1.
  - `req_ready` = (state==IDLE).
  - All outputs are decoded from registered state.
- Both `cntlr_raddr` and `cntlr_waddr` equal the latched `addr[ADDR_WIDTH+1:2]`.
- Load extract:
  - Byte: lane = `addr[1:0]`, bits 8·lane+7:8·lane.
  - Half: bits 16·`addr[1]`+15:16·`addr[1]`.
  - Word: the full word.
  - Sign-extend unless `req_unsigned`=1. `req_unsigned` is ignored for word loads.
  - The result is captured into `rsp_rdata` in RWAIT.
- Store merge:
  - The read word is captured in RWAIT.
  - The addressed byte or half-word is replaced with `req_wdata[7:0]` or `req_wdata[15:0]`.
  - The merged word is driven on `cntlr_wr_data` in WR.
  - A word store drives `req_wdata` directly.
- `cntlr_rd_valid` outside RWAIT is ignored.
- `rsp_err`=0 for every legal access. A store response leaves `rsp_rdata` unchanged.

## Timing

Request accepted at cycle T:

- Load: `cntlr_rd` at T+1; `cntlr_rd_valid` at T+2; `rsp_valid` at T+3; `req_ready` high again at T+4.
- Word store: `cntlr_wr` at T+1; `rsp_valid` at T+2; `req_ready` at T+3.
- Sub-word store: `cntlr_rd` at T+1; read data at T+2; `cntlr_wr` at T+3; `rsp_valid` at T+4; `req_ready` at T+5.
- Fault: `rsp_valid` with `rsp_err` at T+1; `req_ready` at T+2.

Reset behaviour:

- Reset values: state IDLE, `req_ready`=1, and all other outputs 0. Latched address, data and `rsp_rdata` are all 0.
- Reset asserted mid-operation:
  - Returns to IDLE immediately.
  - `cntlr_rd` and `cntlr_wr` drop asynchronously.
  - No response is produced.
  - An in-flight read-modify-write is abandoned. If reset hits before WR, memory is unmodified.
- A request presented while `rst_n` is low is not accepted.

## Test plan

1. Word store to 0x0010 with data 0xDEADBEEF → at T+1 `cntlr_wr`=1, `cntlr_waddr`=4, data 0xDEADBEEF; at T+2 `rsp_valid`=1, `rsp_err`=0.
2. Memory word 4 = 0xDEADBEEF:
   - Signed byte load at 0x13 → `cntlr_raddr`=4 at T+1, `rsp_rdata`=0xFFFFFFDE at T+3.
   - Unsigned byte load at 0x13 → 0x000000DE.
   - Signed half load at 0x12 → 0xFFFFDEAD.
   - Unsigned half load at 0x10 → 0x0000BEEF.
3. Byte store of 0xAA at 0x11 over 0xDEADBEEF → `cntlr_rd` at T+1, `cntlr_wr` at T+3 with 0xDEADAAEF, `rsp_valid` at T+4.
4. Faults:
   - Word load at 0x12 → no `cntlr_rd` or `cntlr_wr`; `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 at T+1.
   - `req_size`=11 → same response.
   - Half store at 0x11 → same response.
5. `req_valid` held high with two loads → `req_ready` low from T+1 to T+3; second request accepted at T+4; its `rsp_valid` at T+7.
6. Reset pulsed during RWAIT of a byte store → `cntlr_wr` never asserted, no `rsp_valid`, memory unchanged; after release `req_ready`=1 and `rsp_rdata`=0.

Source files
------------

// File: rtl/ccm_lsu_adapter.sv
// ccm_lsu_adapter
// Byte-addressed load/store front end for the CCM controller. Handles one
// request at a time, rejects misaligned or reserved-size accesses, extends
// sub-word loads and performs sub-word stores as read-modify-write because
// the controller only writes whole words. Controller read data returns one
// cycle after the read strobe.
module ccm_lsu_adapter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // LSU request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    // LSU response
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // CCM controller read port
    output logic                  cntlr_rd,
    output logic [ADDR_WIDTH-1:0] cntlr_raddr,
    input  logic [DATA_WIDTH-1:0] cntlr_rd_data,
    input  logic                  cntlr_rd_valid,
    // CCM controller write port
    output logic                  cntlr_wr,
    output logic [ADDR_WIDTH-1:0] cntlr_waddr,
    output logic [DATA_WIDTH-1:0] cntlr_wr_data
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RWAIT,
        ST_WR,
        ST_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    // Latched request
    logic                    r_we;
    logic [ADDR_WIDTH+1:0]   r_addr;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [DATA_WIDTH-1:0]   r_wdata;     // store data, replaced by the merged word during RMW
    logic                    r_err;

    // Response data register
    logic [DATA_WIDTH-1:0]   r_rdata;

    logic                    w_accept;
    logic                    w_fault;
    logic                    w_rd_capture;
    logic [1:0]              w_lane;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load_data;
    logic [DATA_WIDTH-1:0]   w_merge_data;

    assign w_accept     = req_valid & (r_state == ST_IDLE);
    assign w_rd_capture = (r_state == ST_RWAIT) & cntlr_rd_valid;
    assign w_lane       = r_addr[1:0];

    // Classify the live request: reserved size or misalignment is a fault.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and no latch is inferred.
        w_fault = 1'b0;
        case (req_size)
            SZ_BYTE: w_fault = 1'b0;
            SZ_HALF: w_fault = req_addr[0];
            SZ_WORD: w_fault = (req_addr[1:0] != 2'b00);
            default: w_fault = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: word stores skip the read, sub-word stores read first.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_fault) begin
                        w_next_state = ST_RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        w_next_state = ST_WR;
                    end else begin
                        w_next_state = ST_RD;
                    end
                end
            end
            ST_RD:    w_next_state = ST_RWAIT;
            ST_RWAIT: begin
                if (cntlr_rd_valid) begin
                    w_next_state = r_we ? ST_WR : ST_RESP;
                end
            end
            ST_WR:    w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Strobes decoded purely from the registered state.
    always_comb begin
        req_ready = 1'b0;
        cntlr_rd  = 1'b0;
        cntlr_wr  = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        case (r_state)
            ST_IDLE: req_ready = 1'b1;
            ST_RD:   cntlr_rd  = 1'b1;
            ST_WR:   cntlr_wr  = 1'b1;
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
            end
            default: ;
        endcase
    end

    // Latch the request on acceptance; fold the merged word in during RMW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_err      <= w_fault;
        end else if (w_rd_capture && r_we) begin
            r_wdata    <= w_merge_data;
        end
    end

    // Load result register: cleared by a fault, updated by a load, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_accept && w_fault) begin
            r_rdata <= '0;
        end else if (w_rd_capture && !r_we) begin
            r_rdata <= w_load_data;
        end
    end

    // Select the addressed byte/half from the returned word and extend it.
    always_comb begin
        w_byte = cntlr_rd_data[8*w_lane +: 8];
        w_half = cntlr_rd_data[16*w_lane[1] +: 16];
        case (r_size)
            SZ_BYTE: w_load_data = {{(DATA_WIDTH-8){w_byte[7] & ~r_unsigned}}, w_byte};
            SZ_HALF: w_load_data = {{(DATA_WIDTH-16){w_half[15] & ~r_unsigned}}, w_half};
            default: w_load_data = cntlr_rd_data;
        endcase
    end

    // Overlay the store byte/half onto the word read back from the CCM.
    always_comb begin
        w_merge_data = cntlr_rd_data;
        if (r_size == SZ_BYTE) begin
            w_merge_data[8*w_lane +: 8] = r_wdata[7:0];
        end else begin
            w_merge_data[16*w_lane[1] +: 16] = r_wdata[15:0];
        end
    end

    assign cntlr_raddr   = r_addr[ADDR_WIDTH+1:2];
    assign cntlr_waddr   = r_addr[ADDR_WIDTH+1:2];
    assign cntlr_wr_data = r_wdata;
    assign rsp_rdata     = r_rdata;

endmodule

// File: tb/tb_ccm_lsu_adapter.sv
// tb_ccm_lsu_adapter
// Directed bench for ccm_lsu_adapter. A word-array CCM stand-in answers reads
// one cycle later. A transaction-level model predicts, per accepted request,
// on which cycle offsets each strobe appears and what the data must be; a
// compare process checks every cycle on the falling edge. Directed tasks add
// literal expectations for the listed scenarios.
module tb_ccm_lsu_adapter;

    localparam int AW = 11;
    localparam int NW = 1 << AW;

    logic           clk;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic           req_we;
    logic [AW+1:0]  req_addr;
    logic [1:0]     req_size;
    logic           req_unsigned;
    logic [31:0]    req_wdata;
    logic           rsp_valid;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;
    logic           cntlr_rd;
    logic [AW-1:0]  cntlr_raddr;
    logic [31:0]    cntlr_rd_data = 32'h0;
    logic           cntlr_rd_valid = 1'b0;
    logic           cntlr_wr;
    logic [AW-1:0]  cntlr_waddr;
    logic [31:0]    cntlr_wr_data;

    logic           spur_en;

    int n_checks = 0;
    int n_errors = 0;

    // CCM stand-in storage and reference model storage
    logic [31:0]    cmem  [0:NW-1];
    logic [31:0]    mmem  [0:NW-1];
    bit             touched [0:NW-1];

    // Model state for the single in-flight request
    bit             m_act;
    int             m_acc;
    bit             m_we;
    logic [AW+1:0]  m_addr;
    bit             m_fault;
    bit             m_has_rd;
    bit             m_has_wr;
    int             m_wr_off;
    int             m_rsp_off;
    logic [31:0]    m_res;
    logic [31:0]    m_wword;
    logic [31:0]    exp_rdata;

    ccm_lsu_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .cntlr_rd       (cntlr_rd),
        .cntlr_raddr    (cntlr_raddr),
        .cntlr_rd_data  (cntlr_rd_data),
        .cntlr_rd_valid (cntlr_rd_valid),
        .cntlr_wr       (cntlr_wr),
        .cntlr_waddr    (cntlr_waddr),
        .cntlr_wr_data  (cntlr_wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    // Loaded value from the word by plain shift/mask; sign extension by
    // wrapping subtraction.
    function automatic logic [31:0] load_result(input logic [31:0] w, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        int unsigned v;
        case (size)
            2'b00: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (!uns && v >= 32'h80) v = v - 32'h100;
            end
            2'b01: begin
                v = (w >> (16 * off[1])) & 32'hFFFF;
                if (!uns && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                               input logic [1:0] off, input logic [1:0] size);
        logic [31:0] mask;
        int          sh;
        if (size == 2'b00) begin
            sh   = 8 * off;
            mask = 32'hFF << sh;
        end else begin
            sh   = 16 * off[1];
            mask = 32'hFFFF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // CCM stand-in: read data one cycle after the strobe; optional junk valids.
    always @(posedge clk) begin
        if (cntlr_wr) cmem[cntlr_waddr] <= cntlr_wr_data;
        cntlr_rd_valid <= cntlr_rd | spur_en;
        cntlr_rd_data  <= cntlr_rd ? cmem[cntlr_raddr] : 32'hBADC0DE5;
    end

    // Compare process: outputs after each rising edge checked on the falling edge.
    initial begin : monitor
        int            cyc;
        int            k;
        bit            e_rd;
        bit            e_wr;
        bit            e_rsp;
        bit            e_ready;
        logic [AW-1:0] widx;
        cyc       = 0;
        m_act     = 1'b0;
        m_acc     = 0;
        exp_rdata = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_act     = 1'b0;
                exp_rdata = 32'h0;
                check("rst_req_ready", 32'(req_ready), 32'd1);
                check("rst_cntlr_rd", 32'(cntlr_rd), 32'd0);
                check("rst_cntlr_wr", 32'(cntlr_wr), 32'd0);
                check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                check("rst_rsp_err", 32'(rsp_err), 32'd0);
                check("rst_rsp_rdata", rsp_rdata, 32'd0);
                check("rst_raddr", 32'(cntlr_raddr), 32'd0);
                check("rst_wr_data", cntlr_wr_data, 32'd0);
            end else begin
                k       = cyc - m_acc;
                e_rd    = m_act && m_has_rd && (k == 1);
                e_wr    = m_act && m_has_wr && (k == m_wr_off);
                e_rsp   = m_act && (k == m_rsp_off);
                e_ready = !(m_act && k >= 1 && k <= m_rsp_off);
                if (e_rsp && (m_fault || !m_we)) exp_rdata = m_res;
                check("req_ready", 32'(req_ready), 32'(e_ready));
                check("cntlr_rd", 32'(cntlr_rd), 32'(e_rd));
                check("cntlr_wr", 32'(cntlr_wr), 32'(e_wr));
                check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
                check("rsp_rdata", rsp_rdata, exp_rdata);
                if (e_rd) check("cntlr_raddr", 32'(cntlr_raddr), 32'(m_addr[AW+1:2]));
                if (e_wr) begin
                    check("cntlr_waddr", 32'(cntlr_waddr), 32'(m_addr[AW+1:2]));
                    check("cntlr_wr_data", cntlr_wr_data, m_wword);
                    mmem[m_addr[AW+1:2]]    = m_wword;
                    touched[m_addr[AW+1:2]] = 1'b1;
                end
                if (e_rsp) begin
                    check("rsp_err", 32'(rsp_err), 32'(m_fault));
                    m_act = 1'b0;
                end else if (!m_act && req_valid === 1'b1) begin
                    m_act     = 1'b1;
                    m_acc     = cyc;
                    m_we      = req_we;
                    m_addr    = req_addr;
                    widx      = req_addr[AW+1:2];
                    m_fault   = (req_size == 2'b11) ||
                                (req_size == 2'b01 && req_addr[0]) ||
                                (req_size == 2'b10 && req_addr[1:0] != 2'b00);
                    m_has_rd  = 1'b0;
                    m_has_wr  = 1'b0;
                    m_wr_off  = 0;
                    m_res     = 32'h0;
                    m_wword   = 32'h0;
                    if (m_fault) begin
                        m_rsp_off = 1;
                    end else if (!req_we) begin
                        m_has_rd  = 1'b1;
                        m_rsp_off = 3;
                        m_res     = load_result(mmem[widx], req_addr[1:0], req_size, req_unsigned);
                    end else if (req_size == 2'b10) begin
                        m_has_wr  = 1'b1;
                        m_wr_off  = 1;
                        m_rsp_off = 2;
                        m_wword   = req_wdata;
                    end else begin
                        m_has_rd  = 1'b1;
                        m_has_wr  = 1'b1;
                        m_wr_off  = 3;
                        m_rsp_off = 4;
                        m_wword   = merge_word(mmem[widx], req_wdata, req_addr[1:0], req_size);
                    end
                end
            end
        end
    end

    // One request, then enough idle cycles for the longest sequence to finish.
    task automatic issue(input logic we, input logic [AW+1:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd);
        @(posedge clk); #1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wd;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Faulting request: error response must be on the very next cycle.
    task automatic fault_req(input string name, input logic we, input logic [AW+1:0] addr,
                             input logic [1:0] size);
        @(posedge clk); #1;
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0000BEEF;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_rsp_err"}, 32'(rsp_err), 32'd1);
        check({name, "_rdata"}, rsp_rdata, 32'd0);
        check({name, "_no_access"}, 32'(cntlr_rd | cntlr_wr), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got time %0t expected completion before 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_addr     = '0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_wdata    = 32'h0;
        spur_en      = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Word store
        issue(1'b1, 13'h0010, 2'b10, 1'b0, 32'hDEADBEEF);
        check("t1_mem4", cmem[4], 32'hDEADBEEF);

        // Loads from 0xDEADBEEF with stray read-valids outside the wait state
        spur_en = 1'b1;
        issue(1'b0, 13'h0013, 2'b00, 1'b0, 32'h0);
        check("t2_lb_s_13", rsp_rdata, 32'hFFFFFFDE);
        issue(1'b0, 13'h0013, 2'b00, 1'b1, 32'h0);
        check("t2_lb_u_13", rsp_rdata, 32'h000000DE);
        issue(1'b0, 13'h0012, 2'b01, 1'b0, 32'h0);
        check("t2_lh_s_12", rsp_rdata, 32'hFFFFDEAD);
        issue(1'b0, 13'h0010, 2'b01, 1'b1, 32'h0);
        check("t2_lh_u_10", rsp_rdata, 32'h0000BEEF);
        issue(1'b0, 13'h0010, 2'b10, 1'b1, 32'h0);
        check("t2_lw_10", rsp_rdata, 32'hDEADBEEF);
        issue(1'b0, 13'h0011, 2'b00, 1'b0, 32'h0);
        check("t2_lb_s_11", rsp_rdata, 32'hFFFFFFBE);
        spur_en = 1'b0;

        // Sub-word stores (read-modify-write)
        issue(1'b1, 13'h0011, 2'b00, 1'b0, 32'h123456AA);
        check("t3_mem4", cmem[4], 32'hDEADAAEF);
        check("t3_rdata_hold", rsp_rdata, 32'hFFFFFFBE);
        issue(1'b1, 13'h0014, 2'b10, 1'b0, 32'h12345678);
        issue(1'b1, 13'h0016, 2'b01, 1'b0, 32'h9999CAFE);
        check("t3_mem5", cmem[5], 32'hCAFE5678);
        issue(1'b0, 13'h0016, 2'b01, 1'b0, 32'h0);
        check("t3_lh_s_16", rsp_rdata, 32'hFFFFCAFE);
        issue(1'b0, 13'h0015, 2'b00, 1'b1, 32'h0);
        check("t3_lb_u_15", rsp_rdata, 32'h00000056);

        // Faults
        fault_req("f_word_mis", 1'b0, 13'h0012, 2'b10);
        fault_req("f_size_rsv", 1'b0, 13'h0010, 2'b11);
        fault_req("f_half_st", 1'b1, 13'h0011, 2'b01);
        check("t4_mem4", cmem[4], 32'hDEADAAEF);

        // Back-to-back loads with req_valid held high
        @(posedge clk); #1;
        req_we       = 1'b0;
        req_addr     = 13'h0014;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_valid    = 1'b1;
        @(posedge clk); #1;
        req_addr = 13'h0017;
        req_size = 2'b00;
        check("t5_ready_t1", 32'(req_ready), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("t5_ready_t4", 32'(req_ready), 32'd1);
        check("t5_first", rsp_rdata, 32'hCAFE5678);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("t5_rsp_t7", 32'(rsp_valid), 32'd1);
        check("t5_second", rsp_rdata, 32'hFFFFFFCA);
        repeat (2) @(posedge clk); #1;

        // Reset during the wait state of a byte store; request during reset ignored
        @(posedge clk); #1;
        req_we    = 1'b1;
        req_addr  = 13'h0010;
        req_size  = 2'b00;
        req_wdata = 32'h00000055;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t6_rd", 32'(cntlr_rd), 32'd1);
        @(posedge clk); #2;
        rst_n     = 1'b0;
        req_we    = 1'b0;
        req_addr  = 13'h0014;
        req_size  = 2'b10;
        req_valid = 1'b1;
        #1;
        check("t6_no_wr", 32'(cntlr_wr), 32'd0);
        check("t6_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #2;
        req_valid = 1'b0;
        rst_n     = 1'b1;
        repeat (4) @(posedge clk); #1;
        check("t6_ready", 32'(req_ready), 32'd1);
        check("t6_rdata", rsp_rdata, 32'd0);
        check("t6_mem4", cmem[4], 32'hDEADAAEF);

        // Reset during the read strobe drops it asynchronously
        @(posedge clk); #1;
        req_we    = 1'b0;
        req_addr  = 13'h0014;
        req_size  = 2'b10;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("t7_rd_before", 32'(cntlr_rd), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rd_async", 32'(cntlr_rd), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Normal operation after reset
        issue(1'b0, 13'h0010, 2'b10, 1'b0, 32'h0);
        check("t8_lw_10", rsp_rdata, 32'hDEADAAEF);

        for (int i = 0; i < NW; i++) begin
            if (touched[i]) check("mem_final", cmem[i], mmem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
